// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared types and constants for the push-button debouncer.
//
// Contents:
//   debounce_state_t       - FSM state encoding for btn_debounce.
//   STABLE_CYCLES_DEFAULT  - default debounce window (5 ms at 50 MHz).
//   sat_inc()              - saturating increment used by the press counter.
// -----------------------------------------------------------------------------
package debounce_pkg;

  // Debounce FSM states.
  //   IDLE         : released level accepted, waiting for a press.
  //   PRESS_WAIT   : pressed level seen, qualifying it for stability.
  //   PRESSED      : pressed level accepted, waiting for a release.
  //   RELEASE_WAIT : released level seen, qualifying it for stability.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  // 250000 cycles = 5 ms at 50 MHz.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 250000;

  // Increment a counter value but hold it at all-ones instead of wrapping.
  // The width is carried by the caller; 32 bits covers any sane counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    logic [31:0] result;
    result = value;
    if (value != max_value) begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Single-bit, two-flop synchronizer for bringing an asynchronous level into
// the clk domain. Reusable for any asynchronous board input.
//
// Parameters:
//   RESET_VALUE - level both flops take during reset. Choose the input's
//                 idle level so downstream logic sees no spurious edge when
//                 reset is released.
//
// Ports:
//   clk - destination clock.
//   rst - asynchronous, active-high reset.
//   d   - asynchronous input level.
//   q   - synchronized level, two clk edges after d is first sampled.
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // First stage may go metastable; it is only ever read by the second stage.
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their inputs
      // from before the edge; blocking here would collapse the chain into
      // one flop and defeat the synchronizer.
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Debounces one raw push-button. The raw level is polarity-corrected,
// synchronized, and then qualified by a four-state FSM that only accepts a
// new level after it has been seen on STABLE_CYCLES consecutive FSM samples
// (in addition to the entry sample). The accepted level drives o_req; the
// accepting transitions produce one-cycle press/release strobes and bump a
// saturating press counter. All outputs are registered so o_req, o_press and
// the counter step come from the same clock edge.
//
// Parameters:
//   STABLE_CYCLES - consecutive stable samples needed to accept a change (>= 2).
//   ACTIVE_LOW    - 1 when the button reads 0 while pressed.
//   COUNT_WIDTH   - width of o_press_count.
//
// Ports:
//   i_clk         - single clock.
//   i_rst         - asynchronous, active-high reset.
//   i_btn         - raw button level, asynchronous, may bounce.
//   o_req         - debounced pressed level.
//   o_press       - one-cycle strobe on an accepted press.
//   o_release     - one-cycle strobe on an accepted release.
//   o_press_count - accepted presses, saturating at all-ones.
// -----------------------------------------------------------------------------
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_btn,
  output logic                   o_req,
  output logic                   o_press,
  output logic                   o_release,
  output logic [COUNT_WIDTH-1:0] o_press_count
);

  // Stability counter only has to reach STABLE_CYCLES-1.
  localparam int unsigned      CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Input path: normalise polarity so 1 always means "pressed", then
  // synchronize. Reset value 0 is the released level, so a button held
  // through reset appears as a fresh press once reset is released.
  // ---------------------------------------------------------------------------
  logic btn_n;
  logic btn_s;

  assign btn_n = i_btn ^ ACTIVE_LOW;

  sync_2ff #(
    .RESET_VALUE(1'b0)
  ) u_sync (
    .clk(i_clk),
    .rst(i_rst),
    .d  (btn_n),
    .q  (btn_s)
  );

  // ---------------------------------------------------------------------------
  // FSM state and stability counter
  // ---------------------------------------------------------------------------
  debounce_state_t  state;
  debounce_state_t  state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so that paths which
    // leave it untouched hold the register value instead of inferring a latch.
    state_nxt = state;
    cnt_nxt   = cnt;

    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          // Bounce: drop back without touching any output.
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release glitch: the pressed level is still the accepted one.
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. The registered outputs are computed from the transition
  // being taken on this edge, so o_req rises, o_press pulses and the counter
  // steps on the very edge the FSM enters PRESSED.
  // ---------------------------------------------------------------------------
  logic                   press_nxt;
  logic                   release_nxt;
  logic                   req_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;

  always_comb begin
    press_nxt   = (state == PRESS_WAIT)   && (state_nxt == PRESSED);
    release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
    req_nxt     = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    count_nxt   = o_press_count;
    if (press_nxt) begin
      count_nxt = COUNT_WIDTH'(sat_inc(32'(o_press_count), 32'(COUNT_MAX)));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_req         <= 1'b0;
      o_press       <= 1'b0;
      o_release     <= 1'b0;
      o_press_count <= '0;
    end else begin
      o_req         <= req_nxt;
      o_press       <= press_nxt;
      o_release     <= release_nxt;
      o_press_count <= count_nxt;
    end
  end

endmodule : btn_debounce
